gf_inv_8: RTL and testbench



---
 rtl/gf_inv_8.sv | 174 +++++++++++++++++
 tb/tb_gf_inv_8.sv | 128 ++++++++++++
 2 files changed

// File: rtl/gf_inv_8.sv
// Registered GF(2^8) multiplicative inverter (AES field, 0x11B) built on the
// composite field GF((2^4)^2): GF(16) = GF(2)[x]/(x^4+x+1), outer poly y^2+y+lambda, lambda = 0xC.

// GF(16) general multiplier modulo x^4+x+1.
module gf4_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);
  logic [6:0] prod_s;

  // Carry-less product, then fold x^4..x^6 back using x^4 = x + 1.
  always_comb begin
    prod_s = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        prod_s = prod_s ^ ({3'd0, a} << i);
      end else begin
        prod_s = prod_s;
      end
    end
    p[0] = prod_s[0] ^ prod_s[4];
    p[1] = prod_s[1] ^ prod_s[4] ^ prod_s[5];
    p[2] = prod_s[2] ^ prod_s[5] ^ prod_s[6];
    p[3] = prod_s[3] ^ prod_s[6];
  end
endmodule

// GF(16) squarer: a linear map, since squaring is the Frobenius automorphism.
module gf4_sq (
  input  logic [3:0] a,
  output logic [3:0] q
);
  // Square as a fixed XOR network.
  always_comb begin
    q[0] = a[0] ^ a[2];
    q[1] = a[2];
    q[2] = a[1] ^ a[3];
    q[3] = a[3];
  end
endmodule

// GF(16) constant multiplier by lambda = 0xC (x^3 + x^2).
module gf4_scale_lambda (
  input  logic [3:0] a,
  output logic [3:0] q
);
  // Fixed XOR network for a * (x^3 + x^2) mod x^4+x+1.
  always_comb begin
    q[0] = a[1] ^ a[2];
    q[1] = a[1] ^ a[3];
    q[2] = a[0] ^ a[2];
    q[3] = a[0] ^ a[1] ^ a[3];
  end
endmodule

// GF(16) inverter with inv(0) = 0.
module gf4_inv (
  input  logic [3:0] a,
  output logic [3:0] q
);
  // Sixteen-entry lookup; small enough to flatten into gates.
  always_comb begin
    case (a)
      4'h0:    q = 4'h0;
      4'h1:    q = 4'h1;
      4'h2:    q = 4'h9;
      4'h3:    q = 4'hE;
      4'h4:    q = 4'hD;
      4'h5:    q = 4'hB;
      4'h6:    q = 4'h7;
      4'h7:    q = 4'h6;
      4'h8:    q = 4'hF;
      4'h9:    q = 4'h2;
      4'hA:    q = 4'hC;
      4'hB:    q = 4'h5;
      4'hC:    q = 4'hA;
      4'hD:    q = 4'h4;
      4'hE:    q = 4'h3;
      4'hF:    q = 4'h8;
      default: q = 4'h0;
    endcase
  end
endmodule

module gf_inv_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic       valid_out,
  output logic [7:0] data_out
);
  // delta: columns are beta^0..beta^7, beta = 0x5F a root of 0x11B in the composite field.
  function automatic logic [7:0] iso_map(input logic [7:0] q);
    logic [7:0] y;
    y[0] = q[0] ^ q[1] ^ q[2] ^ q[5] ^ q[7];
    y[1] = q[1] ^ q[3] ^ q[5] ^ q[6] ^ q[7];
    y[2] = q[1] ^ q[3] ^ q[4] ^ q[6] ^ q[7];
    y[3] = q[1] ^ q[3] ^ q[5] ^ q[6];
    y[4] = q[1] ^ q[5] ^ q[7];
    y[5] = q[2] ^ q[3];
    y[6] = q[1] ^ q[4] ^ q[6] ^ q[7];
    y[7] = q[5] ^ q[7];
    return y;
  endfunction

  // delta^-1, the GF(2) inverse of the matrix above.
  function automatic logic [7:0] iso_unmap(input logic [7:0] y);
    logic [7:0] q;
    q[0] = y[0] ^ y[2] ^ y[4] ^ y[5] ^ y[6];
    q[1] = y[4] ^ y[7];
    q[2] = y[2] ^ y[5] ^ y[6];
    q[3] = y[2] ^ y[6];
    q[4] = y[2] ^ y[3] ^ y[7];
    q[5] = y[1] ^ y[3] ^ y[7];
    q[6] = y[1] ^ y[2] ^ y[4] ^ y[6];
    q[7] = y[1] ^ y[3];
    return q;
  endfunction

  logic [7:0] map_s;
  logic [3:0] ah_s, al_s;
  logic [3:0] ah_sq_s, al_sq_s, ah_sq_l_s, ah_al_s;
  logic [3:0] d_s, d_inv_s, ah_xor_al_s, bh_s, bl_s;
  logic [7:0] inv_s;
  logic [7:0] data_r;
  logic       valid_r;

  // Map into the composite basis and split into nibbles.
  always_comb begin
    map_s       = iso_map(data_in);
    ah_s        = map_s[7:4];
    al_s        = map_s[3:0];
    ah_xor_al_s = map_s[7:4] ^ map_s[3:0];
  end

  gf4_sq           u_sq_ah  (.a(ah_s),    .q(ah_sq_s));
  gf4_scale_lambda u_scale  (.a(ah_sq_s), .q(ah_sq_l_s));
  gf4_mul          u_mul_hl (.a(ah_s),    .b(al_s),    .p(ah_al_s));
  gf4_sq           u_sq_al  (.a(al_s),    .q(al_sq_s));

  // Norm of (ah*y + al); zero only for the zero byte.
  always_comb begin
    d_s = ah_sq_l_s ^ ah_al_s ^ al_sq_s;
  end

  gf4_inv          u_inv    (.a(d_s),         .q(d_inv_s));
  gf4_mul          u_mul_bh (.a(ah_s),        .b(d_inv_s), .p(bh_s));
  gf4_mul          u_mul_bl (.a(ah_xor_al_s), .b(d_inv_s), .p(bl_s));

  // Back to the polynomial basis.
  always_comb begin
    inv_s = iso_unmap({bh_s, bl_s});
  end

  // Single output stage; reset drops any byte presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_in;
      if (valid_in) begin
        data_r <= inv_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;
endmodule

// File: tb/tb_gf_inv_8.sv
// Directed and exhaustive bench for gf_inv_8: reset, latency, hold, inverse
// property checked against an independent GF(2^8) multiplier, mid-stream reset.
module tb_gf_inv_8;
  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [7:0] data_in;
  logic       valid_out;
  logic [7:0] data_out;

  int n_vec;
  int n_bad;
  logic [7:0] inv_tab [256];
  logic [7:0] dir_in  [7];
  logic [7:0] dir_exp [7];

  gf_inv_8 dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-and-add multiply reduced by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      if (x[7]) x = (x << 1) ^ 8'h1B;
      else      x = x << 1;
    end
    return acc;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    dir_in  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h74, 8'h53};
    dir_exp = '{8'h00, 8'h01, 8'h8D, 8'hF6, 8'h74, 8'h10, 8'hCA};

    rst = 1'b1; valid_in = 1'b1; data_in = 8'h53;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_data", data_out, 8'h00);
      check("rst_valid", {7'd0, valid_out}, 8'h00);
    end
    rst = 1'b0; valid_in = 1'b0;
    tick();
    check("post_rst_data", data_out, 8'h00);
    check("post_rst_valid", {7'd0, valid_out}, 8'h00);

    // Back-to-back directed vectors.
    for (int i = 0; i < 7; i++) begin
      valid_in = 1'b1; data_in = dir_in[i];
      tick();
      check("dir_data", data_out, dir_exp[i]);
      check("dir_valid", {7'd0, valid_out}, 8'h01);
    end

    // Hold while idle.
    valid_in = 1'b1; data_in = 8'h10;
    tick();
    check("hold_load", data_out, 8'h74);
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      check("hold_data", data_out, 8'h74);
      check("hold_valid", {7'd0, valid_out}, 8'h00);
    end

    // Exhaustive: product with input must be 1.
    for (int a = 0; a < 256; a++) begin
      valid_in = 1'b1; data_in = a[7:0];
      tick();
      check("exh_valid", {7'd0, valid_out}, 8'h01);
      if (a == 0) check("exh_zero", data_out, 8'h00);
      else        check("exh_prod", gmul(a[7:0], data_out), 8'h01);
      inv_tab[a] = data_out;
    end
    // Involution: inv(inv(a)) = a.
    for (int a = 0; a < 256; a++) begin
      data_in = inv_tab[a];
      tick();
      check("exh_invol", data_out, a[7:0]);
    end

    // Reset mid-stream.
    valid_in = 1'b1; data_in = 8'h02;
    tick();
    check("mid_first", data_out, 8'h8D);
    check("mid_first_v", {7'd0, valid_out}, 8'h01);
    rst = 1'b1; data_in = 8'h03;
    tick();
    check("mid_rst", data_out, 8'h00);
    check("mid_rst_v", {7'd0, valid_out}, 8'h00);
    rst = 1'b0; data_in = 8'h10;
    tick();
    check("mid_after", data_out, 8'h74);
    check("mid_after_v", {7'd0, valid_out}, 8'h01);
    valid_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
